// File: rtl/triangle_raster_engine.sv
`default_nettype none
// ============================================================================
// Module   : triangle_raster_engine
// Purpose  : Pops one packed triangle from a first-word-fall-through FIFO,
//            computes its screen-clipped bounding box and scans the box at
//            one pixel per clock with incremental edge functions. Covered
//            pixels leave as flat-shaded fragments over valid/ready.
// Options  : BACKFACE_CULL_EN - when defined, clockwise triangles (A2<0)
//            are dropped instead of rasterised.
// Revision : 1.0 - initial release
// ============================================================================
module triangle_raster_engine #(
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int ZW       = 12,
  parameter int CW       = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                       clk_100MHz,
  input  logic                       reset_ah,
  input  logic [3*(XW+YW+ZW)-1:0]    triangle_coords,
  input  logic [CW-1:0]              triangle_color,
  input  logic                       fifo_empty,
  output logic                       t_r,
  output logic                       frag_valid,
  input  logic                       frag_ready,
  output logic [XW-1:0]              x,
  output logic [YW-1:0]              y,
  output logic [ZW-1:0]              z,
  output logic [CW-1:0]              color,
  output logic                       busy,
  output logic                       tri_done
);

  localparam int VW = XW + YW + ZW;
  localparam int EW = XW + YW + 3;
  localparam logic [XW-1:0] XLIM = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YLIM = YW'(SCREEN_H - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [XW-1:0]        vx_q [3];
  logic [YW-1:0]        vy_q [3];
  logic [ZW-1:0]        z0_q;
  logic [CW-1:0]        tcol_q;
  logic signed [EW-1:0] area_q;
  logic [XW-1:0]        xmin_q, xmax_q, cx_q;
  logic [YW-1:0]        ymin_q, ymax_q, cy_q;
  logic signed [EW-1:0] a_q [3], b_q [3], e_q [3], erow_q [3];
  logic                 last_q;
  logic                 fv_q, done_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [ZW-1:0]        z_q;
  logic [CW-1:0]        color_q;

  // Differences are formed directly at edge-function width; the value equals
  // the one-bit-wider signed difference sign-extended.
  function automatic logic signed [EW-1:0] sdx(input logic [XW-1:0] p, input logic [XW-1:0] q);
    return $signed(EW'(p)) - $signed(EW'(q));
  endfunction

  function automatic logic signed [EW-1:0] sdy(input logic [YW-1:0] p, input logic [YW-1:0] q);
    return $signed(EW'(p)) - $signed(EW'(q));
  endfunction

  // Fragment z is flat from vertex 0, so the other two z fields are unused.
  logic unused_zbits;
  assign unused_zbits = ^{triangle_coords[VW+XW+YW +: ZW], triangle_coords[2*VW+XW+YW +: ZW]};

  logic signed [EW-1:0] area_w;
  assign area_w = sdx(vx_q[1], vx_q[0]) * sdy(vy_q[2], vy_q[0])
                - sdx(vx_q[2], vx_q[0]) * sdy(vy_q[1], vy_q[0]);

  logic [XW-1:0] xmin_w, xmax_w;
  logic [YW-1:0] ymin_w, ymax_w;

  // Vertex bounding box; coordinates are unsigned so only the top needs clamping,
  // leaving min > max when the whole triangle lies off screen.
  always_comb begin
    xmin_w = vx_q[0];
    xmax_w = vx_q[0];
    ymin_w = vy_q[0];
    ymax_w = vy_q[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_q[i] < xmin_w) xmin_w = vx_q[i];
      if (vx_q[i] > xmax_w) xmax_w = vx_q[i];
      if (vy_q[i] < ymin_w) ymin_w = vy_q[i];
      if (vy_q[i] > ymax_w) ymax_w = vy_q[i];
    end
    if (xmax_w > XLIM) xmax_w = XLIM;
    if (ymax_w > YLIM) ymax_w = YLIM;
  end

  // Edge i runs from vertex (i+1)%3 to (i+2)%3: E = A*(px-xa) + B*(py-ya) with
  // A = ya-yb (x step) and B = xb-xa (y step). A2>0 means E>=0 inside.
  logic                 init_w, neg_w;
  logic signed [EW-1:0] a_w [3], b_w [3], einit_w [3];
  logic signed [EW-1:0] cur_e_w [3], cur_row_w [3], cur_a_w [3], cur_b_w [3];

  assign init_w = (state_q == S_INIT);
  assign neg_w  = area_q[EW-1];

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    localparam int IA = (gi + 1) % 3;
    localparam int IB = (gi + 2) % 3;
    assign a_w[gi]     = sdy(vy_q[IA], vy_q[IB]);
    assign b_w[gi]     = sdx(vx_q[IB], vx_q[IA]);
    assign einit_w[gi] = a_w[gi] * sdx(xmin_q, vx_q[IA]) + b_w[gi] * sdy(ymin_q, vy_q[IA]);
    // INIT evaluates the first pixel straight from the freshly formed values.
    assign cur_e_w[gi]   = init_w ? (neg_w ? -einit_w[gi] : einit_w[gi]) : e_q[gi];
    assign cur_row_w[gi] = init_w ? (neg_w ? -einit_w[gi] : einit_w[gi]) : erow_q[gi];
    assign cur_a_w[gi]   = init_w ? (neg_w ? -a_w[gi] : a_w[gi]) : a_q[gi];
    assign cur_b_w[gi]   = init_w ? (neg_w ? -b_w[gi] : b_w[gi]) : b_q[gi];
  end

  logic [XW-1:0] cur_x_w;
  logic [YW-1:0] cur_y_w;
  logic          cov_w, adv_w, reject_w, step_w;

  assign cur_x_w = init_w ? xmin_q : cx_q;
  assign cur_y_w = init_w ? ymin_q : cy_q;
  assign cov_w   = !cur_e_w[0][EW-1] && !cur_e_w[1][EW-1] && !cur_e_w[2][EW-1];
  assign adv_w   = !fv_q || frag_ready;
`ifdef BACKFACE_CULL_EN
  assign reject_w = (area_q == '0) || neg_w || (xmin_q > xmax_q) || (ymin_q > ymax_q);
`else
  assign reject_w = (area_q == '0) || (xmin_q > xmax_q) || (ymin_q > ymax_q);
`endif
  assign step_w = (init_w && !reject_w) || ((state_q == S_SCAN) && adv_w && !last_q);

  // Sequencing: pop, setup, init, scan until drained, one-cycle done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_SETUP;
      S_SETUP: state_d = S_INIT;
      S_INIT:  state_d = reject_w ? S_DONE : S_SCAN;
      S_SCAN:  if (adv_w && last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: triangle capture, setup, edge stepping and the fragment register.
  always_ff @(posedge clk_100MHz) begin
    if (reset_ah) begin
      state_q <= S_IDLE;
      z0_q    <= '0;
      tcol_q  <= '0;
      area_q  <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      last_q  <= 1'b0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      color_q <= '0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        e_q[i]    <= '0;
        erow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: if (!fifo_empty) begin
          for (int i = 0; i < 3; i++) begin
            vx_q[i] <= triangle_coords[i*VW +: XW];
            vy_q[i] <= triangle_coords[i*VW+XW +: YW];
          end
          z0_q   <= triangle_coords[XW+YW +: ZW];
          tcol_q <= triangle_color;
        end
        S_SETUP: begin
          area_q <= area_w;
          xmin_q <= xmin_w;
          xmax_q <= xmax_w;
          ymin_q <= ymin_w;
          ymax_q <= ymax_w;
        end
        S_INIT: begin
          last_q <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            a_q[i] <= cur_a_w[i];
            b_q[i] <= cur_b_w[i];
          end
        end
        S_SCAN: if (adv_w && last_q) fv_q <= 1'b0;
        default: ;
      endcase
      if (step_w) begin
        fv_q <= cov_w;
        if (cov_w) begin
          x_q     <= cur_x_w;
          y_q     <= cur_y_w;
          z_q     <= z0_q;
          color_q <= tcol_q;
        end
        if (cur_x_w == xmax_q) begin
          cx_q <= xmin_q;
          if (cur_y_w == ymax_q) last_q <= 1'b1;
          else                   cy_q   <= cur_y_w + YW'(1);
          for (int i = 0; i < 3; i++) begin
            erow_q[i] <= cur_row_w[i] + cur_b_w[i];
            e_q[i]    <= cur_row_w[i] + cur_b_w[i];
          end
        end else begin
          cx_q <= cur_x_w + XW'(1);
          cy_q <= cur_y_w;
          for (int i = 0; i < 3; i++) begin
            e_q[i]    <= cur_e_w[i] + cur_a_w[i];
            erow_q[i] <= cur_row_w[i];
          end
        end
      end
    end
  end

  // The pop strobe is qualified by reset so every output reads 0 under reset.
  assign t_r        = (state_q == S_IDLE) && !fifo_empty && !reset_ah;
  assign frag_valid = fv_q;
  assign x          = x_q;
  assign y          = y_q;
  assign z          = z_q;
  assign color      = color_q;
  assign busy       = (state_q != S_IDLE);
  assign tri_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_triangle_raster_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_triangle_raster_engine
// Purpose  : Directed self-checking bench for triangle_raster_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_raster_engine;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int ZW = 12;
  localparam int CW = 8;
  localparam int TW = 3 * (XW + YW + ZW);

  typedef struct packed {
    logic [TW-1:0] c;
    logic [CW-1:0] col;
  } tri_t;

  logic          clk_100MHz = 1'b0;
  logic          reset_ah   = 1'b1;
  logic [TW-1:0] triangle_coords = '0;
  logic [CW-1:0] triangle_color  = '0;
  logic          fifo_empty = 1'b1;
  logic          frag_ready = 1'b1;
  logic          t_r, frag_valid, busy, tri_done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ZW-1:0] z;
  logic [CW-1:0] color;

  triangle_raster_engine dut (
    .clk_100MHz      (clk_100MHz),
    .reset_ah        (reset_ah),
    .triangle_coords (triangle_coords),
    .triangle_color  (triangle_color),
    .fifo_empty      (fifo_empty),
    .t_r             (t_r),
    .frag_valid      (frag_valid),
    .frag_ready      (frag_ready),
    .x               (x),
    .y               (y),
    .z               (z),
    .color           (color),
    .busy            (busy),
    .tri_done        (tri_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int   tests = 0;
  int   fails = 0;
  tri_t fq[$];
  int   fx[$], fy[$], fz[$], fc[$];
  int   ex[$], ey[$];
  int   ndone, ntr, tr_cyc, first_fv, done_cyc, nstall, stall_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] tri3(input int x0, input int y0, input int x1,
                                         input int y1, input int x2, input int y2, input int z0);
    logic [31:0] v0, v1, v2;
    v0 = {12'(z0), 10'(y0), 10'(x0)};
    v1 = {12'(7),  10'(y1), 10'(x1)};
    v2 = {12'(7),  10'(y2), 10'(x2)};
    return {v2, v1, v0};
  endfunction

  task automatic drive_fifo();
    triangle_coords = (fq.size() != 0) ? fq[0].c : '0;
    triangle_color  = (fq.size() != 0) ? fq[0].col : '0;
    fifo_empty      = (fq.size() == 0);
  endtask

  task automatic push_tri(input logic [TW-1:0] c, input logic [CW-1:0] col);
    tri_t t;
    t.c = c;
    t.col = col;
    fq.push_back(t);
    drive_fifo();
  endtask

  // Entered and left at posedge+1; outputs observed at posedge+2.
  task automatic run(input string tag, input int mode, input int max_cyc, input int stop_after);
    bit          pend, ps, timed_out, rdy;
    logic [40:0] sv;
    fx.delete(); fy.delete(); fz.delete(); fc.delete();
    ndone = 0; ntr = 0; tr_cyc = -1; first_fv = -1; done_cyc = -1;
    nstall = 0; stall_bad = 0; pend = 0; ps = 0; timed_out = 1; sv = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (pend) begin
        fq.delete(0);
        drive_fifo();
        pend = 0;
      end
      #1;
      if (t_r) begin
        ntr++;
        if (tr_cyc < 0) tr_cyc = cyc;
        pend = 1;
      end
      if (frag_valid && first_fv < 0) first_fv = cyc;
      if (ps) begin
        nstall++;
        if ({frag_valid, x, y, z, color} !== sv) stall_bad++;
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      frag_ready = rdy;
      if (frag_valid && rdy) begin
        fx.push_back(int'(x)); fy.push_back(int'(y));
        fz.push_back(int'(z)); fc.push_back(int'(color));
      end
      ps = frag_valid && !rdy;
      sv = {frag_valid, x, y, z, color};
      if (tri_done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (stop_after > 0 && fx.size() == stop_after) begin
        timed_out = 0;
        break;
      end
      @(posedge clk_100MHz); #1;
      if (done_cyc >= 0) begin
        timed_out = 0;
        break;
      end
    end
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
  endtask

  task automatic check_list(input string tag, input int zexp, input int cexp);
    int bad;
    bad = 0;
    chk({tag, "_count"}, 64'(fx.size()), 64'(ex.size()));
    for (int i = 0; i < fx.size() && i < ex.size(); i++)
      if (fx[i] != ex[i] || fy[i] != ey[i] || fz[i] != zexp || fc[i] != cexp) bad++;
    chk({tag, "_order"}, 64'(bad), 64'd0);
  endtask

  task automatic build_small();
    ex.delete(); ey.delete();
    for (int yy = 0; yy <= 4; yy++)
      for (int xx = 0; xx <= 4 - yy; xx++) begin
        ex.push_back(xx);
        ey.push_back(yy);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_100MHz);
    #1;
    chk("reset_outputs", 64'({t_r, frag_valid, busy, tri_done, x, y, z, color}), 64'd0);
    reset_ah = 1'b0;

    // Right triangle, counter-clockwise
    push_tri(tri3(0, 0, 4, 0, 0, 4, 5), 8'hE0);
    run("tri1", 0, 200, 0);
    build_small();
    check_list("tri1", 5, 'hE0);
    chk("tri1_done", 64'(ndone), 64'd1);
    chk("tri1_pops", 64'(ntr), 64'd1);
    chk("tri1_latency", 64'(first_fv - tr_cyc), 64'd3);
    chk("tri1_idle", 64'(busy), 64'd0);

    // Colinear vertices
    push_tri(tri3(0, 0, 2, 2, 4, 4, 3), 8'h03);
    run("colin", 0, 50, 0);
    chk("colin_frags", 64'(fx.size()), 64'd0);
    chk("colin_done", 64'(ndone), 64'd1);
    chk("colin_done_lat", 64'(done_cyc - tr_cyc), 64'd3);
    chk("colin_idle", 64'(busy), 64'd0);

    // Clockwise winding
    push_tri(tri3(0, 0, 0, 4, 4, 0, 5), 8'hE0);
    run("wind", 0, 200, 0);
    build_small();
`ifdef BACKFACE_CULL_EN
    ex.delete(); ey.delete();
`endif
    check_list("wind", 5, 'hE0);
    chk("wind_done", 64'(ndone), 64'd1);

    // Screen clipping
    push_tri(tri3(630, 470, 700, 470, 630, 520, 'h123), 8'h1C);
    run("clip", 0, 400, 0);
    ex.delete(); ey.delete();
    for (int yy = 470; yy < 480; yy++)
      for (int xx = 630; xx < 640; xx++) begin
        ex.push_back(xx);
        ey.push_back(yy);
      end
    check_list("clip", 'h123, 'h1C);
    chk("clip_done", 64'(ndone), 64'd1);

    // Random backpressure
    push_tri(tri3(0, 0, 4, 0, 0, 4, 5), 8'hE0);
    run("bp", 1, 800, 0);
    build_small();
    check_list("bp", 5, 'hE0);
    chk("bp_stall_stable", 64'(stall_bad), 64'd0);
    chk("bp_stalled_some", 64'(nstall > 0), 64'd1);
    chk("bp_done", 64'(ndone), 64'd1);
    frag_ready = 1'b1;

    // Reset mid-scan with a second triangle queued
    push_tri(tri3(0, 0, 4, 0, 0, 4, 5), 8'hE0);
    push_tri(tri3(0, 0, 4, 0, 0, 4, 9), 8'h1C);
    run("rst_a", 0, 200, 5);
    chk("rst_a_frags", 64'(fx.size()), 64'd5);
    chk("rst_a_nodone", 64'(ndone), 64'd0);
    reset_ah = 1'b1;
    @(posedge clk_100MHz); #1;
    chk("rst_outputs", 64'({t_r, frag_valid, busy, tri_done, x, y, z, color}), 64'd0);
    @(posedge clk_100MHz); #1;
    chk("rst_nodone", 64'(tri_done), 64'd0);
    reset_ah = 1'b0;
    run("rst_b", 0, 200, 0);
    build_small();
    check_list("rst_b", 9, 'h1C);
    chk("rst_b_pops", 64'(ntr), 64'd1);
    chk("rst_b_latency", 64'(first_fv - tr_cyc), 64'd3);
    chk("rst_b_done", 64'(ndone), 64'd1);
    chk("fifo_drained", 64'(fifo_empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
